// File: rtl/mem_bist_pkg.sv
// Shared definitions for the RAM self-test sequencer:
// FSM encoding, pattern select codes and the data pattern generator.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_NADDR = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_ONES  = 2'd3;

    // Wide enough for any supported RAM; callers size-cast the result down.
    localparam int PAT_W = 128;

    function automatic logic [PAT_W-1:0] pat(
        input logic [1:0]       sel,
        input logic [PAT_W-1:0] addr
    );
        logic [PAT_W-1:0] v;
        unique case (sel)
            PAT_ADDR:  v = addr;
            PAT_NADDR: v = ~addr;
            PAT_CHECK: v = addr[0] ? {(PAT_W/2){2'b10}}
                                   : {(PAT_W/2){2'b01}};
            default:   v = '1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_bist_rdpipe.sv
// Read-tracking shift pipe: carries {valid, addr} alongside the RAM
// read latency so the compare sees the address that produced ram_dout.
module mem_bist_rdpipe #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_vld,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_busy
);

    logic [RD_LAT-1:0] r_vld;
    logic [ADDR_W-1:0] r_addr [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_push;
            r_addr[0] <= i_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    assign o_vld  = r_vld[RD_LAT-1];
    assign o_addr = r_addr[RD_LAT-1];
    assign o_busy = |r_vld;

endmodule

// File: rtl/mem_bist_ctrl.sv
// BIST sequencer: writes a pattern to every RAM word, reads it back,
// and reports pass/fail, saturating error count and first bad address.
module mem_bist_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    import mem_bist_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERR_W-1:0]  r_err;
    logic [ADDR_W-1:0] r_first;

    logic              w_accept;
    logic              w_last;
    logic [1:0]        w_sel_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_din_nxt;
    logic              w_we_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_pass_nxt;
    logic              w_pipe_vld;
    logic [ADDR_W-1:0] w_pipe_addr;
    logic              w_pipe_busy;
    logic [DATA_W-1:0] w_exp;
    logic              w_mis;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_last    = (r_addr == LAST_ADDR);
    assign w_sel_nxt = w_accept ? pattern_sel : r_sel;

    // Pushed from the registered address, so the pipe tail lines up
    // with the cycle in which the RAM presents that word.
    mem_bist_rdpipe #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_rdpipe (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_state == ST_READ),
        .i_addr (r_addr),
        .o_vld  (w_pipe_vld),
        .o_addr (w_pipe_addr),
        .o_busy (w_pipe_busy)
    );

    assign w_exp = DATA_W'(pat(r_sel, PAT_W'(w_pipe_addr)));
    assign w_mis = w_pipe_vld && (ram_dout != w_exp);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_WRITE;
            ST_WRITE: if (w_last) w_state_nxt = ST_READ;
            ST_READ:  if (w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!w_pipe_busy) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt = '0;
        if (r_state == ST_WRITE || r_state == ST_READ) begin
            w_addr_nxt = r_addr + ADDR_W'(1);
        end
        w_we_nxt   = (w_state_nxt == ST_WRITE);
        w_din_nxt  = '0;
        if (w_we_nxt) begin
            w_din_nxt = DATA_W'(pat(w_sel_nxt, PAT_W'(w_addr_nxt)));
        end
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt = r_busy;
        w_pass_nxt = r_pass;
        if (w_accept) begin
            w_busy_nxt = 1'b1;
            w_pass_nxt = 1'b0;
        end else if (w_done_nxt) begin
            w_busy_nxt = 1'b0;
            w_pass_nxt = (r_err == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sel   <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
        end else begin
            r_sel  <= w_sel_nxt;
            r_addr <= w_addr_nxt;
            r_din  <= w_din_nxt;
            r_we   <= w_we_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_pass <= w_pass_nxt;
            if (w_accept) begin
                r_err   <= '0;
                r_first <= '0;
            end else if (w_mis) begin
                if (r_err != '1) r_err <= r_err + ERR_W'(1);
                if (r_err == '0) r_first <= w_pipe_addr;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;
    assign ram_addr       = r_addr;
    assign ram_din        = r_din;
    assign ram_we         = r_we;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: two instances (RD_LAT=1/ERR_W=16 and
// RD_LAT=3/ERR_W=4) against behavioural RAMs with fault injection.
module tb_mem_bist_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic          rst1, go1, busy1, done1, pass1, we1;
    logic [1:0]    sel1;
    logic [15:0]   err1;
    logic [AW-1:0] first1, addr1;
    logic [DW-1:0] din1, dout1;

    logic          rst3, go3, busy3, done3, pass3, we3;
    logic [1:0]    sel3;
    logic [3:0]    err3;
    logic [AW-1:0] first3, addr3;
    logic [DW-1:0] din3, dout3;

    mem_bist_ctrl #(
        .ADDR_W (AW), .DATA_W (DW), .RD_LAT (1), .ERR_W (16)
    ) u_dut1 (
        .clk (clk), .rst (rst1), .start (go1), .pattern_sel (sel1),
        .busy (busy1), .done (done1), .pass (pass1),
        .err_count (err1), .first_err_addr (first1),
        .ram_addr (addr1), .ram_din (din1), .ram_we (we1),
        .ram_dout (dout1)
    );

    mem_bist_ctrl #(
        .ADDR_W (AW), .DATA_W (DW), .RD_LAT (3), .ERR_W (4)
    ) u_dut3 (
        .clk (clk), .rst (rst3), .start (go3), .pattern_sel (sel3),
        .busy (busy3), .done (done3), .pass (pass3),
        .err_count (err3), .first_err_addr (first3),
        .ram_addr (addr3), .ram_din (din3), .ram_we (we3),
        .ram_dout (dout3)
    );

    // Fault modes: 0 none, 1 bit5 stuck-at-0 at a, 2 bit0 flip at a and b, 3 every word inverted
    function automatic logic [31:0] flt(input int m, input logic [9:0] a,
                                        input logic [9:0] b, input logic [9:0] ad,
                                        input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (m == 1 && ad == a) r[5] = 1'b0;
        if (m == 2 && (ad == a || ad == b)) r[0] = ~r[0];
        if (m == 3) r = ~d;
        return r;
    endfunction

    logic [31:0] mem1 [DEPTH];
    logic [31:0] mem3 [DEPTH];
    logic [31:0] rp3 [3];
    int          fm1 = 0, fm3 = 0;
    logic [9:0]  fa1 = '0, fb1 = '0, fa3 = '0, fb3 = '0;

    always @(posedge clk) begin
        if (we1) mem1[addr1] <= din1;
        dout1 <= flt(fm1, fa1, fb1, addr1, mem1[addr1]);
    end

    always @(posedge clk) begin
        if (we3) mem3[addr3] <= din3;
        rp3[0] <= flt(fm3, fa3, fb3, addr3, mem3[addr3]);
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign dout3 = rp3[2];

    typedef struct {
        int   t0;
        logic ok;
        int   err;
        int   first;
        int   lat;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   dn1 = 0;
    int   dn3 = 0;

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1 === 1'b1) begin
            dn1++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL u1_done_unexpected: got done at cycle %0d, required none", cyc);
            end else begin
                e = q1.pop_front();
                if (pass1 !== e.ok || err1 !== 16'(e.err) ||
                    first1 !== 10'(e.first) || (cyc - e.t0) != e.lat) begin
                    errors++;
                    $display("FAIL u1_result: got pass=%b err=%0d first=%h lat=%0d, required pass=%b err=%0d first=%h lat=%0d",
                             pass1, err1, first1, cyc - e.t0, e.ok, e.err, e.first, e.lat);
                end
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (done3 === 1'b1) begin
            dn3++;
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL u3_done_unexpected: got done at cycle %0d, required none", cyc);
            end else begin
                e = q3.pop_front();
                if (pass3 !== e.ok || err3 !== 4'(e.err) ||
                    first3 !== 10'(e.first) || (cyc - e.t0) != e.lat) begin
                    errors++;
                    $display("FAIL u3_result: got pass=%b err=%0d first=%h lat=%0d, required pass=%b err=%0d first=%h lat=%0d",
                             pass3, err3, first3, cyc - e.t0, e.ok, e.err, e.first, e.lat);
                end
            end
        end
    end

    task automatic kick1(input logic [1:0] s);
        @(negedge clk);
        sel1 = s;
        go1  = 1'b1;
        @(negedge clk);
        go1  = 1'b0;
    endtask

    task automatic kick3(input logic [1:0] s);
        @(negedge clk);
        sel3 = s;
        go3  = 1'b1;
        @(negedge clk);
        go3  = 1'b0;
    endtask

    task automatic wait_q1();
        for (int i = 0; i < 3000 && q1.size() != 0; i++) @(negedge clk);
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL u1_timeout: got %0d pending runs, required 0", q1.size());
            q1.delete();
        end
    endtask

    task automatic wait_q3();
        for (int i = 0; i < 3000 && q3.size() != 0; i++) @(negedge clk);
        checks++;
        if (q3.size() != 0) begin
            errors++;
            $display("FAIL u3_timeout: got %0d pending runs, required 0", q3.size());
            q3.delete();
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b0; go1 = 1'b0; sel1 = 2'd0;
        rst3 = 1'b0; go3 = 1'b0; sel3 = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy1, done1, we1, pass1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_u1_flags: got %b, required 0000", {busy1, done1, we1, pass1});
        end
        checks++;
        if (err1 !== 16'd0 || first1 !== 10'd0) begin
            errors++;
            $display("FAIL reset_u1_status: got err=%0d first=%h, required 0 0", err1, first1);
        end
        checks++;
        if (addr1 !== 10'd0 || din1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_u1_ram: got addr=%h din=%h, required 0 0", addr1, din1);
        end
        checks++;
        if ({busy3, done3, we3, pass3, err3, first3, addr3} !== '0) begin
            errors++;
            $display("FAIL reset_u3: got busy=%b done=%b we=%b err=%0d, required all 0", busy3, done3, we3, err3);
        end
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean();
        fm1 = 0;
        kick1(2'd0);
        q1.push_back('{t0: cyc, ok: 1'b1, err: 0, first: 0, lat: 2050});
        checks++;
        if (busy1 !== 1'b1 || we1 !== 1'b1 || addr1 !== 10'd0 || din1 !== 32'd0) begin
            errors++;
            $display("FAIL clean_first_write: got busy=%b we=%b addr=%h din=%h, required 1 1 000 0", busy1, we1, addr1, din1);
        end
        @(negedge clk);
        checks++;
        if (addr1 !== 10'd1 || din1 !== 32'd1) begin
            errors++;
            $display("FAIL clean_second_write: got addr=%h din=%h, required 001 1", addr1, din1);
        end
        wait_q1();
        checks++;
        if (mem1[1023] !== 32'h0000_03FF) begin
            errors++;
            $display("FAIL clean_ram_last: got %h, required 000003ff", mem1[1023]);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (pass1 !== 1'b1 || err1 !== 16'd0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL clean_hold: got pass=%b err=%0d busy=%b, required 1 0 0", pass1, err1, busy1);
        end
    endtask

    task automatic test_stuck_bit();
        fm1 = 1; fa1 = 10'h020;
        kick1(2'd3);
        q1.push_back('{t0: cyc, ok: 1'b0, err: 1, first: 32, lat: 2050});
        wait_q1();
        checks++;
        if (mem1[10'h020] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stuck_ram_word: got %h, required ffffffff", mem1[10'h020]);
        end
    endtask

    task automatic test_multi_fault();
        fm1 = 2; fa1 = 10'h010; fb1 = 10'h200;
        kick1(2'd1);
        q1.push_back('{t0: cyc, ok: 1'b0, err: 2, first: 16, lat: 2050});
        wait_q1();
        fm1 = 0;
    endtask

    task automatic test_abort();
        int   d0;
        logic found;
        found = 1'b0;
        kick1(2'd0);
        for (int i = 0; i < 400 && !found; i++) begin
            if (addr1 == 10'd300 && we1 === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_300: got addr=%h we=%b, required 12c 1", addr1, we1);
        end
        rst1 = 1'b0;
        d0 = dn1;
        @(negedge clk);
        rst1 = 1'b1;
        checks++;
        if (we1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_next_cycle: got we=%b busy=%b done=%b, required 0 0 0", we1, busy1, done1);
        end
        repeat (2200) @(negedge clk);
        checks++;
        if (dn1 != d0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, required 0", dn1 - d0);
        end
    endtask

    task automatic test_ignore_start();
        logic seen;
        seen = 1'b0;
        kick1(2'd0);
        q1.push_back('{t0: cyc, ok: 1'b1, err: 0, first: 0, lat: 2050});
        repeat (1500) @(negedge clk);
        checks++;
        if (we1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL ignore_in_read: got we=%b busy=%b, required 0 1", we1, busy1);
        end
        sel1 = 2'd3;
        go1  = 1'b1;
        @(negedge clk);
        go1  = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (done1 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ignore_done_seen: got no done, required one");
        end
        sel1 = 2'd2;
        go1  = 1'b1;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_in_done: got busy=%b, required 0", busy1);
        end
        @(negedge clk);
        go1 = 1'b0;
        q1.push_back('{t0: cyc, ok: 1'b1, err: 0, first: 0, lat: 2050});
        checks++;
        if (busy1 !== 1'b1 || we1 !== 1'b1 || din1 !== 32'h5555_5555) begin
            errors++;
            $display("FAIL accept_after_done: got busy=%b we=%b din=%h, required 1 1 55555555", busy1, we1, din1);
        end
    endtask

    task automatic test_back_to_back();
        wait_q1();
        checks++;
        if (mem1[10'h3FF] !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL b2b_ram_last: got %h, required aaaaaaaa", mem1[10'h3FF]);
        end
    endtask

    task automatic test_pipe();
        fm3 = 0;
        kick3(2'd2);
        q3.push_back('{t0: cyc, ok: 1'b1, err: 0, first: 0, lat: 2052});
        wait_q3();
        fm3 = 1; fa3 = 10'h3FF;
        kick3(2'd2);
        q3.push_back('{t0: cyc, ok: 1'b0, err: 1, first: 1023, lat: 2052});
        wait_q3();
    endtask

    task automatic test_saturate();
        fm3 = 3;
        kick3(2'd0);
        q3.push_back('{t0: cyc, ok: 1'b0, err: 15, first: 0, lat: 2052});
        wait_q3();
        repeat (3) @(negedge clk);
        checks++;
        if (err3 !== 4'hF) begin
            errors++;
            $display("FAIL saturate_hold: got %0d, required 15", err3);
        end
        fm3 = 0;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuck_bit();
        test_multi_fault();
        test_abort();
        test_ignore_start();
        test_back_to_back();
        test_pipe();
        test_saturate();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
